store_buffer: RTL and testbench
===============================

# store_buffer

Post-commit store buffer between the LSU store-execute path and the D-cache write port, downstream of the ROB commit outputs. Executed stores are held speculatively in program order. They are marked committed when the ROB retires them (`commit_valid` & `commit_is_store`, matched by `commit_rob_idx`), then drained one per handshake to the D-cache. The block also supplies store-to-load forwarding and discards uncommitted stores on flush.

## Interface
Parameters:
- SB_ENTRIES, 8, buffer depth (power of two)
- ROB_SIZE, core_pkg::ROB_ENTRIES, sizes ROB index fields (IDX_BITS = $clog2(ROB_SIZE))

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- st_wr_en  in  1  LSU writes an executed store (stores arrive in program order)
- st_wr_rob_idx  in  IDX_BITS  ROB index of that store
- st_wr_addr  in  32  byte address; bits [1:0] ignored, word-aligned storage
- st_wr_data  in  32  store data, byte-lane aligned
- st_wr_be  in  4  byte enables, nonzero
- commit_valid  in  ISSUE_WIDTH  ROB commit slot valid
- commit_is_store  in  ISSUE_WIDTH  committing slot is a store
- commit_rob_idx  in  ISSUE_WIDTH x IDX_BITS  ROB index per commit slot
- flush_en  in  1  pipeline flush; drops all uncommitted entries
- dc_req_valid  out  1  head entry committed and presented to D-cache
- dc_req_addr  out  32  word address {addr[31:2],2'b00}
- dc_req_data  out  32  store data
- dc_req_be  out  4  byte enables
- dc_req_ready  in  1  D-cache accepts request this cycle
- ld_fwd_addr  in  32  load lookup address (word compare)
- ld_fwd_be  in  4  bytes the load needs
- ld_fwd_hit  out  1  youngest matching entry covers all ld_fwd_be bytes
- ld_fwd_stall  out  1  youngest matching entry overlaps only partially
- ld_fwd_data  out  32  data of the hitting entry
- sb_full  out  1  count == SB_ENTRIES
- sb_empty  out  1  count == 0
- sb_err  out  1  sticky protocol error

## Operation
- Circular FIFO with three pointers: head (oldest), cmt (first uncommitted), tail (next free). Counters: count and ncommitted, each $clog2(SB_ENTRIES+1) bits. All pointers wrap modulo SB_ENTRIES.
- Write: when st_wr_en & !sb_full, store entry at tail and increment tail. When st_wr_en & sb_full, drop the write and set sb_err.
- Commit: evaluate slots in order 0..ISSUE_WIDTH-1. Each slot with commit_valid & commit_is_store marks the entry at the next cmt position committed and advances cmt, so two store commits in one cycle advance cmt by 2.
  - Set sb_err if that entry's rob_idx differs from commit_rob_idx, or if no uncommitted entry exists. Advance cmt regardless.
- Drain: dc_req_* is driven combinationally from the head entry. dc_req_valid = (ncommitted > 0). On dc_req_valid & dc_req_ready, free head and advance head.
- Flush: tail <= cmt, after applying this cycle's commits. Committed entries survive and keep draining. A same-cycle st_wr is discarded. A same-cycle drain proceeds.
- Forwarding (combinational): compare ld_fwd_addr[31:2] against all valid entries and select the youngest match, tail-relative.
  - All requested bytes covered (ld_fwd_be & ~be == 0): ld_fwd_hit=1.
  - Otherwise ld_fwd_stall=1.
  - No match: both 0.
  - ld_fwd_data is 0 unless ld_fwd_hit.
- Reset: head=cmt=tail=0, counts 0, all valid bits 0. Output reset values: dc_req_valid=0, dc_req_addr/data/be=0, ld_fwd_hit=0, ld_fwd_stall=0, ld_fwd_data=0, sb_full=0, sb_empty=1, sb_err=0. Reset mid-drain abandons the request; no hold requirement.

## Timing
- st_wr at edge N: entry forwardable from cycle N+1; sb_full reflects it at N+1.
- Commit at edge N: dc_req_valid can rise in cycle N+1 at the earliest.
- Handshake: dc_req_* stays stable while valid & !ready. After acceptance at edge N, the next committed entry is presented in N+1, giving 1 store per cycle sustained.
- sb_full is based on pre-edge count. A write while full is rejected even if a drain frees a slot on the same edge.
- count update per edge: count + write_accepted − drain_accepted, and set to ncommitted after drain on flush.
- Simultaneous write, commit, and drain on one edge are all legal and applied together.

## Structure
- core_pkg: add SB_ENTRIES constant and an sb_entry_t packed struct {valid, committed, rob_idx, addr[31:2], data, be}.
- Sub-module: sb_fwd_match, the combinational youngest-match priority search, parameterised on SB_ENTRIES.
- Target is roughly 200–300 lines of RTL.

## Test plan
- Reset, then write 3 stores (rob 4,5,6; addr 0x100/0x104/0x108; be 4'hF) with no commits -> dc_req_valid=0, count=3, sb_empty=0.
- Commit rob 4 and rob 5 in one cycle, dc_req_ready=1 -> next cycle dc_req 0x100; the following cycle 0x104; then dc_req_valid=0.
- Hold dc_req_ready=0 for 5 cycles with one committed entry -> dc_req_addr/data/be stay constant and head does not advance.
- Fill 8 entries, assert another st_wr -> write dropped, sb_err=1, sb_full=1. Then drain with wrap-around -> FIFO order is preserved across index 7→0.
- Stores to 0x200 (be 4'hF, 0xAAAAAAAA) then 0x200 (be 4'h3, 0x0000BBBB): load be 4'h1 -> hit, data 0x0000BBBB; load be 4'hC -> stall.
- 2 committed + 3 uncommitted entries, flush_en -> count=2, tail=cmt, only the 2 committed stores reach the D-cache; a same-cycle st_wr is discarded.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared constants and entry layout for the post-commit store buffer.
package store_buffer_pkg;

  localparam int ROB_ENTRIES = 32;
  localparam int ISSUE_WIDTH = 2;
  localparam int SB_ENTRIES  = 8;
  localparam int ROB_IDX_W   = $clog2(ROB_ENTRIES);

  typedef struct packed {
    logic                 valid;
    logic                 committed;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [29:0]          addr;
    logic [31:0]          data;
    logic [3:0]           be;
  } sb_entry_t;

  function automatic logic be_covers(
    input logic [3:0] need,
    input logic [3:0] have
  );
    return (need & ~have) == 4'b0000;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// D-cache write request channel: valid/ready handshake with a
// word address, data and byte enables.
interface store_buffer_if;

  logic        dc_req_valid;
  logic [31:0] dc_req_addr;
  logic [31:0] dc_req_data;
  logic [3:0]  dc_req_be;
  logic        dc_req_ready;

  modport master (
    output dc_req_valid,
    output dc_req_addr,
    output dc_req_data,
    output dc_req_be,
    input  dc_req_ready
  );

  modport slave (
    input  dc_req_valid,
    input  dc_req_addr,
    input  dc_req_data,
    input  dc_req_be,
    output dc_req_ready
  );

endinterface

// File: rtl/store_buffer_fwd_match.sv
// Youngest-first word-address match over the store buffer entries,
// classifying the result as full-cover hit or partial-overlap stall.
module store_buffer_fwd_match
  import store_buffer_pkg::*;
#(
  parameter  int N  = 8,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]        valid_i,
  input  logic [N-1:0][29:0]  addr_i,
  input  logic [N-1:0][31:0]  data_i,
  input  logic [N-1:0][3:0]   be_i,
  input  logic [PW-1:0]       tail_i,
  input  logic [29:0]         ld_waddr_i,
  input  logic [3:0]          ld_be_i,
  output logic                hit_o,
  output logic                stall_o,
  output logic [31:0]         data_o
);

  logic          found;
  logic [PW-1:0] sel;
  logic [PW-1:0] idx;
  logic          covers;

  // Walk backwards from tail so the first match is the youngest store.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = tail_i - PW'(k);
      if (!found && valid_i[idx] && addr_i[idx] == ld_waddr_i) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign covers  = be_covers(ld_be_i, be_i[sel]);
  assign hit_o   = found && covers;
  assign stall_o = found && !covers;
  assign data_o  = hit_o ? data_i[sel] : '0;

endmodule

// File: rtl/store_buffer.sv
// Post-commit store buffer: speculative in-order store FIFO, commit
// marking from the ROB, D-cache drain and store-to-load forwarding.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter  int SB_ENTRIES = store_buffer_pkg::SB_ENTRIES,
  parameter  int ROB_SIZE   = ROB_ENTRIES,
  localparam int IDX_BITS   = $clog2(ROB_SIZE)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                st_wr_en,
  input  logic [IDX_BITS-1:0]                 st_wr_rob_idx,
  input  logic [31:0]                         st_wr_addr,
  input  logic [31:0]                         st_wr_data,
  input  logic [3:0]                          st_wr_be,
  input  logic [ISSUE_WIDTH-1:0]              commit_valid,
  input  logic [ISSUE_WIDTH-1:0]              commit_is_store,
  input  logic [ISSUE_WIDTH-1:0][IDX_BITS-1:0] commit_rob_idx,
  input  logic                                flush_en,
  store_buffer_if.master                      dc,
  input  logic [31:0]                         ld_fwd_addr,
  input  logic [3:0]                          ld_fwd_be,
  output logic                                ld_fwd_hit,
  output logic                                ld_fwd_stall,
  output logic [31:0]                         ld_fwd_data,
  output logic                                sb_full,
  output logic                                sb_empty,
  output logic                                sb_err
);

  localparam int PW = $clog2(SB_ENTRIES);
  localparam int CW = $clog2(SB_ENTRIES + 1);

  sb_entry_t [SB_ENTRIES-1:0] mem_q, mem_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] cmt_q, cmt_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] ncmt_q, ncmt_d;
  logic          err_q, err_d;

  logic          full;
  logic          req_v;
  logic          drain;
  logic          wr_ok;
  logic [CW-1:0] avail;

  logic [SB_ENTRIES-1:0]       f_valid;
  logic [SB_ENTRIES-1:0][29:0] f_addr;
  logic [SB_ENTRIES-1:0][31:0] f_data;
  logic [SB_ENTRIES-1:0][3:0]  f_be;

  logic unused_lo;
  assign unused_lo = ^{st_wr_addr[1:0], ld_fwd_addr[1:0]};

  assign full  = count_q == CW'(SB_ENTRIES);
  assign req_v = ncmt_q != '0;
  assign drain = req_v && dc.dc_req_ready;
  // A flush squashes the same-cycle write along with younger entries.
  assign wr_ok = st_wr_en && !full && !flush_en;

  assign dc.dc_req_valid = req_v;
  assign dc.dc_req_addr  = req_v ? {mem_q[head_q].addr, 2'b00} : '0;
  assign dc.dc_req_data  = req_v ? mem_q[head_q].data : '0;
  assign dc.dc_req_be    = req_v ? mem_q[head_q].be : '0;

  assign sb_full  = full;
  assign sb_empty = count_q == '0;
  assign sb_err   = err_q;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    cmt_d   = cmt_q;
    tail_d  = tail_q;
    count_d = count_q;
    ncmt_d  = ncmt_q;
    err_d   = err_q;
    avail   = count_q - ncmt_q;

    if (st_wr_en && full) begin
      err_d = 1'b1;
    end

    for (int s = 0; s < ISSUE_WIDTH; s++) begin
      if (commit_valid[s] && commit_is_store[s]) begin
        if (avail == '0) begin
          err_d = 1'b1;
        end else begin
          if (mem_d[cmt_d].rob_idx != ROB_IDX_W'(commit_rob_idx[s])) begin
            err_d = 1'b1;
          end
          mem_d[cmt_d].committed = 1'b1;
          ncmt_d = ncmt_d + CW'(1);
          avail  = avail - CW'(1);
        end
        cmt_d = cmt_d + PW'(1);
      end
    end

    if (drain) begin
      mem_d[head_q] = '0;
      head_d  = head_q + PW'(1);
      ncmt_d  = ncmt_d - CW'(1);
      count_d = count_d - CW'(1);
    end

    if (wr_ok) begin
      mem_d[tail_q] = '{valid:     1'b1,
                        committed: 1'b0,
                        rob_idx:   ROB_IDX_W'(st_wr_rob_idx),
                        addr:      st_wr_addr[31:2],
                        data:      st_wr_data,
                        be:        st_wr_be};
      tail_d  = tail_q + PW'(1);
      count_d = count_d + CW'(1);
    end

    // Committed entries are architecturally done and survive the flush.
    if (flush_en) begin
      for (int i = 0; i < SB_ENTRIES; i++) begin
        if (mem_d[i].valid && !mem_d[i].committed) begin
          mem_d[i] = '0;
        end
      end
      tail_d  = cmt_d;
      count_d = ncmt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q   <= '0;
      head_q  <= '0;
      cmt_q   <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ncmt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      cmt_q   <= cmt_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ncmt_q  <= ncmt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < SB_ENTRIES; i++) begin
      f_valid[i] = mem_q[i].valid;
      f_addr[i]  = mem_q[i].addr;
      f_data[i]  = mem_q[i].data;
      f_be[i]    = mem_q[i].be;
    end
  end

  store_buffer_fwd_match #(
    .N (SB_ENTRIES)
  ) u_fwd (
    .valid_i    (f_valid),
    .addr_i     (f_addr),
    .data_i     (f_data),
    .be_i       (f_be),
    .tail_i     (tail_q),
    .ld_waddr_i (ld_fwd_addr[31:2]),
    .ld_be_i    (ld_fwd_be),
    .hit_o      (ld_fwd_hit),
    .stall_o    (ld_fwd_stall),
    .data_o     (ld_fwd_data)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int N  = 8;
  localparam int IW = ISSUE_WIDTH;
  localparam int IB = $clog2(ROB_ENTRIES);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic st_wr_en;
  logic [IB-1:0] st_wr_rob_idx;
  logic [31:0] st_wr_addr, st_wr_data;
  logic [3:0] st_wr_be;
  logic [IW-1:0] commit_valid, commit_is_store;
  logic [IW-1:0][IB-1:0] commit_rob_idx;
  logic flush_en;
  logic [31:0] ld_fwd_addr;
  logic [3:0] ld_fwd_be;
  logic ld_fwd_hit, ld_fwd_stall;
  logic [31:0] ld_fwd_data;
  logic sb_full, sb_empty, sb_err;

  store_buffer_if dcif();

  store_buffer #(.SB_ENTRIES(N), .ROB_SIZE(ROB_ENTRIES)) dut (
    .clk(clk), .reset(reset),
    .st_wr_en(st_wr_en), .st_wr_rob_idx(st_wr_rob_idx),
    .st_wr_addr(st_wr_addr), .st_wr_data(st_wr_data), .st_wr_be(st_wr_be),
    .commit_valid(commit_valid), .commit_is_store(commit_is_store),
    .commit_rob_idx(commit_rob_idx), .flush_en(flush_en),
    .dc(dcif),
    .ld_fwd_addr(ld_fwd_addr), .ld_fwd_be(ld_fwd_be),
    .ld_fwd_hit(ld_fwd_hit), .ld_fwd_stall(ld_fwd_stall),
    .ld_fwd_data(ld_fwd_data),
    .sb_full(sb_full), .sb_empty(sb_empty), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          rob;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ment_t;

  ment_t mq[$];
  int    mnc;
  bit    merr;
  logic [31:0] got[$];

  function automatic logic [105:0] exp_vec();
    logic v, h, s, fnd, f, e;
    logic [31:0] a, d, fd;
    logic [3:0] b;
    v = mnc > 0; a = 0; d = 0; b = 0;
    h = 0; s = 0; fd = 0; fnd = 0;
    if (v) begin
      a = {mq[0].a[31:2], 2'b00};
      d = mq[0].d;
      b = mq[0].be;
    end
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!fnd && mq[i].a[31:2] == ld_fwd_addr[31:2]) begin
        fnd = 1;
        if ((ld_fwd_be & ~mq[i].be) == 4'b0) begin
          h = 1; fd = mq[i].d;
        end else s = 1;
      end
    end
    f = mq.size() == N;
    e = mq.size() == 0;
    return {v, a, d, b, h, s, fd, f, e, merr};
  endfunction

  function automatic logic [105:0] act_vec();
    return {dcif.dc_req_valid, dcif.dc_req_addr, dcif.dc_req_data,
            dcif.dc_req_be, ld_fwd_hit, ld_fwd_stall, ld_fwd_data,
            sb_full, sb_empty, sb_err};
  endfunction

  task automatic model_edge();
    bit full = mq.size() == N;
    bit drain = (mnc > 0) && dcif.dc_req_ready;
    if (st_wr_en && full) merr = 1;
    for (int s = 0; s < IW; s++) begin
      if (commit_valid[s] && commit_is_store[s]) begin
        if (mnc >= mq.size()) merr = 1;
        else begin
          if (mq[mnc].rob != int'(commit_rob_idx[s])) merr = 1;
          mnc++;
        end
      end
    end
    if (drain) begin
      mq.delete(0);
      mnc--;
    end
    if (st_wr_en && !full && !flush_en)
      mq.push_back('{int'(st_wr_rob_idx), st_wr_addr, st_wr_data, st_wr_be});
    if (flush_en)
      while (mq.size() > mnc) mq.delete(mq.size() - 1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    st_wr_en = 0; st_wr_rob_idx = 0; st_wr_addr = 0;
    st_wr_data = 0; st_wr_be = 0;
    commit_valid = 0; commit_is_store = 0; commit_rob_idx = '0;
    flush_en = 0; dcif.dc_req_ready = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    mq.delete(); mnc = 0; merr = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic wr(input int rob, input logic [31:0] a,
                    input logic [31:0] d, input logic [3:0] be);
    st_wr_en = 1; st_wr_rob_idx = IB'(rob);
    st_wr_addr = a; st_wr_data = d; st_wr_be = be;
    tick();
    st_wr_en = 0;
  endtask

  task automatic set_cmt(input bit v0, input int r0,
                         input bit v1, input int r1);
    commit_valid = {v1, v0};
    commit_is_store = {v1, v0};
    commit_rob_idx[0] = IB'(r0);
    commit_rob_idx[1] = IB'(r1);
  endtask

  task automatic test_reset();
    logic [105:0] rst_exp;
    idle();
    reset = 1;
    mq.delete(); mnc = 0; merr = 0;
    ld_fwd_addr = 32'h100; ld_fwd_be = 4'hF;
    st_wr_en = 1; st_wr_addr = 32'h100; st_wr_data = 32'h55; st_wr_be = 4'hF;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_exp = {1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (act_vec() !== rst_exp) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=%h", act_vec(), rst_exp);
    end
    st_wr_en = 0;
    reset = 0;
  endtask

  task automatic test_write_commit_drain();
    do_reset();
    for (int i = 0; i < 3; i++) wr(4 + i, 32'h100 + 4 * i, 32'h1000 + i, 4'hF);
    ld_fwd_addr = 32'h104; ld_fwd_be = 4'hF;
    #1;
    checks++;
    if ({dcif.dc_req_valid, sb_empty, sb_full, ld_fwd_hit, ld_fwd_data}
        !== {1'b0, 1'b0, 1'b0, 1'b1, 32'h1001}) begin
      errors++;
      $display("FAIL three_writes got=%b/%b/%b/%b/%h exp=0/0/0/1/00001001",
               dcif.dc_req_valid, sb_empty, sb_full, ld_fwd_hit, ld_fwd_data);
    end
    set_cmt(1, 4, 1, 5);
    dcif.dc_req_ready = 1;
    #1;
    checks++;
    if (dcif.dc_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL commit_latency got=%b exp=0", dcif.dc_req_valid);
    end
    tick();
    idle();
    dcif.dc_req_ready = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({dcif.dc_req_valid, dcif.dc_req_addr} !== {1'b1, 32'h100 + 32'(4 * k)}) begin
        errors++;
        $display("FAIL drain_%0d got=%b/%h exp=1/%h", k,
                 dcif.dc_req_valid, dcif.dc_req_addr, 32'h100 + 4 * k);
      end
      tick();
    end
    #1;
    checks++;
    if (act_vec() !== exp_vec() || dcif.dc_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_done got=%h exp=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_hold();
    logic [67:0] ref_req;
    set_cmt(1, 6, 0, 0);
    dcif.dc_req_ready = 0;
    tick();
    idle();
    ref_req = {32'h108, 32'h1002, 4'hF};
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if ({dcif.dc_req_valid, dcif.dc_req_addr, dcif.dc_req_data, dcif.dc_req_be}
          !== {1'b1, ref_req}) begin
        errors++;
        $display("FAIL hold_%0d got=%b/%h/%h/%h exp=1/%h", k, dcif.dc_req_valid,
                 dcif.dc_req_addr, dcif.dc_req_data, dcif.dc_req_be, ref_req);
      end
      tick();
    end
    dcif.dc_req_ready = 1;
    tick();
    #1;
    checks++;
    if ({dcif.dc_req_valid, sb_empty} !== 2'b01) begin
      errors++;
      $display("FAIL hold_release got=%b/%b exp=0/1", dcif.dc_req_valid, sb_empty);
    end
  endtask

  task automatic test_full_wrap();
    int c;
    do_reset();
    for (int i = 0; i < 5; i++) wr(i, 32'h40 + 4 * i, $urandom, 4'hF);
    dcif.dc_req_ready = 1;
    set_cmt(1, 0, 1, 1); tick();
    set_cmt(1, 2, 1, 3); tick();
    set_cmt(1, 4, 0, 0); tick();
    set_cmt(0, 0, 0, 0);
    for (int k = 0; k < 20 && !sb_empty; k++) tick();
    dcif.dc_req_ready = 0;
    #1;
    checks++;
    if (sb_empty !== 1'b1) begin
      errors++;
      $display("FAIL prewrap_empty got=%b exp=1", sb_empty);
    end
    for (int i = 0; i < 8; i++) wr(10 + i, 32'h400 + 4 * i, $urandom, 4'hF);
    #1;
    checks++;
    if ({sb_full, sb_err} !== 2'b10) begin
      errors++;
      $display("FAIL fill got=%b/%b exp=1/0", sb_full, sb_err);
    end
    wr(18, 32'h800, 32'hDEAD, 4'hF);
    ld_fwd_addr = 32'h800; ld_fwd_be = 4'hF;
    #1;
    checks++;
    if ({sb_full, sb_err, ld_fwd_hit, ld_fwd_stall} !== 4'b1100) begin
      errors++;
      $display("FAIL overflow got=%b/%b/%b/%b exp=1/1/0/0",
               sb_full, sb_err, ld_fwd_hit, ld_fwd_stall);
    end
    got.delete();
    c = 0;
    dcif.dc_req_ready = 1;
    for (int cyc = 0; cyc < 40 && got.size() < 8; cyc++) begin
      commit_valid = 0; commit_is_store = 0;
      for (int s = 0; s < IW; s++) begin
        if (c < 8) begin
          commit_valid[s] = 1; commit_is_store[s] = 1;
          commit_rob_idx[s] = IB'(10 + c);
          c++;
        end
      end
      #1;
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL wrap_cycle_%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
      end
      if (dcif.dc_req_valid) got.push_back(dcif.dc_req_addr);
      tick();
    end
    idle();
    checks++;
    if (got.size() != 8) begin
      errors++;
      $display("FAIL wrap_count got=%0d exp=8", got.size());
    end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] !== 32'h400 + 32'(4 * k)) begin
        errors++;
        $display("FAIL wrap_order_%0d got=%h exp=%h", k, got[k], 32'h400 + 4 * k);
      end
    end
  endtask

  task automatic test_forward();
    do_reset();
    wr(1, 32'h200, 32'hAAAAAAAA, 4'hF);
    wr(2, 32'h200, 32'h0000BBBB, 4'h3);
    ld_fwd_addr = 32'h200; ld_fwd_be = 4'h1;
    #1;
    checks++;
    if ({ld_fwd_hit, ld_fwd_stall, ld_fwd_data} !== {2'b10, 32'h0000BBBB}) begin
      errors++;
      $display("FAIL fwd_hit got=%b/%b/%h exp=1/0/0000bbbb",
               ld_fwd_hit, ld_fwd_stall, ld_fwd_data);
    end
    ld_fwd_be = 4'hC;
    #1;
    checks++;
    if ({ld_fwd_hit, ld_fwd_stall, ld_fwd_data} !== {2'b01, 32'h0}) begin
      errors++;
      $display("FAIL fwd_stall got=%b/%b/%h exp=0/1/0",
               ld_fwd_hit, ld_fwd_stall, ld_fwd_data);
    end
    ld_fwd_addr = 32'h203; ld_fwd_be = 4'h2;
    #1;
    checks++;
    if ({ld_fwd_hit, ld_fwd_data} !== {1'b1, 32'h0000BBBB}) begin
      errors++;
      $display("FAIL fwd_lowbits got=%b/%h exp=1/0000bbbb", ld_fwd_hit, ld_fwd_data);
    end
    ld_fwd_addr = 32'h204; ld_fwd_be = 4'hF;
    #1;
    checks++;
    if ({ld_fwd_hit, ld_fwd_stall, ld_fwd_data} !== {2'b00, 32'h0}) begin
      errors++;
      $display("FAIL fwd_miss got=%b/%b/%h exp=0/0/0",
               ld_fwd_hit, ld_fwd_stall, ld_fwd_data);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) wr(20 + i, 32'h500 + 4 * i, 32'hC0 + i, 4'hF);
    set_cmt(1, 20, 1, 21);
    tick();
    idle();
    flush_en = 1;
    st_wr_en = 1; st_wr_rob_idx = IB'(25);
    st_wr_addr = 32'h600; st_wr_data = 32'h66; st_wr_be = 4'hF;
    tick();
    idle();
    ld_fwd_addr = 32'h508; ld_fwd_be = 4'hF;
    #1;
    checks++;
    if ({ld_fwd_hit, ld_fwd_stall, sb_empty, dcif.dc_req_valid} !== 4'b0001) begin
      errors++;
      $display("FAIL flush_squash got=%b/%b/%b/%b exp=0/0/0/1",
               ld_fwd_hit, ld_fwd_stall, sb_empty, dcif.dc_req_valid);
    end
    ld_fwd_addr = 32'h600;
    #1;
    checks++;
    if (ld_fwd_hit !== 1'b0) begin
      errors++;
      $display("FAIL flush_same_cycle_write got=%b exp=0", ld_fwd_hit);
    end
    got.delete();
    dcif.dc_req_ready = 1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      if (dcif.dc_req_valid) got.push_back(dcif.dc_req_addr);
      tick();
    end
    #1;
    checks++;
    if (got.size() != 2 || sb_empty !== 1'b1) begin
      errors++;
      $display("FAIL flush_drain_count got=%0d/%b exp=2/1", got.size(), sb_empty);
    end
    for (int k = 0; k < got.size() && k < 2; k++) begin
      checks++;
      if (got[k] !== 32'h500 + 32'(4 * k)) begin
        errors++;
        $display("FAIL flush_drain_%0d got=%h exp=%h", k, got[k], 32'h500 + 4 * k);
      end
    end
    dcif.dc_req_ready = 0;
    wr(26, 32'h700, 32'h77, 4'hF);
    set_cmt(1, 26, 0, 0);
    tick();
    idle();
    #1;
    checks++;
    if ({dcif.dc_req_valid, dcif.dc_req_addr, sb_err} !== {1'b1, 32'h700, 1'b0}) begin
      errors++;
      $display("FAIL post_flush_write got=%b/%h/%b exp=1/00000700/0",
               dcif.dc_req_valid, dcif.dc_req_addr, sb_err);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) wr(i, 32'hA00 + 4 * i, 32'hB0 + i, 4'hF);
    set_cmt(1, 0, 1, 1); tick();
    set_cmt(1, 2, 1, 3); tick();
    idle();
    dcif.dc_req_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({dcif.dc_req_valid, dcif.dc_req_addr} !== {1'b1, 32'hA00 + 32'(4 * k)}) begin
        errors++;
        $display("FAIL b2b_%0d got=%b/%h exp=1/%h", k,
                 dcif.dc_req_valid, dcif.dc_req_addr, 32'hA00 + 4 * k);
      end
      tick();
    end
    #1;
    checks++;
    if (sb_empty !== 1'b1) begin
      errors++;
      $display("FAIL b2b_empty got=%b exp=1", sb_empty);
    end
  endtask

  task automatic test_random();
    int nrob;
    int u, k, j;
    do_reset();
    nrob = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      st_wr_en = 1'($urandom_range(0, 1));
      st_wr_rob_idx = IB'(nrob);
      nrob++;
      st_wr_addr = 32'h300 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
      st_wr_data = $urandom;
      st_wr_be = 4'($urandom_range(1, 15));
      u = mq.size() - mnc;
      k = $urandom_range(0, 2);
      if (k > u) k = u;
      j = 0;
      for (int s = 0; s < IW; s++) begin
        if (j < k && $urandom_range(0, 3) != 0) begin
          commit_valid[s] = 1; commit_is_store[s] = 1;
          commit_rob_idx[s] = IB'(mq[mnc + j].rob);
          j++;
        end else begin
          commit_valid[s] = 1'($urandom_range(0, 1));
          commit_is_store[s] = 0;
          commit_rob_idx[s] = IB'($urandom);
        end
      end
      flush_en = $urandom_range(0, 19) == 0;
      dcif.dc_req_ready = $urandom_range(0, 9) < 6;
      ld_fwd_addr = 32'h300 + 32'(4 * $urandom_range(0, 4));
      ld_fwd_be = 4'($urandom_range(1, 15));
      #1;
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_%0d got=%h exp=%h", cyc, act_vec(), exp_vec());
      end
      tick();
    end
    idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    idle();
    ld_fwd_addr = 0;
    ld_fwd_be = 0;
    test_reset();
    test_write_commit_drain();
    test_hold();
    test_full_wrap();
    test_forward();
    test_flush();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
